mem_stage_sram_ctrl: RTL

- Multi-cycle data-memory controller for the MEM stage of the 5-stage MIPS pipeline.
- Accepts a load/store from the EXE/MEM register and drives an external single-port 32-bit SRAM with a fixed wait-state count.
- Returns load data to the MEM/WB register.
- Deasserts ready, so the top level freezes PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB, until the access completes.

---
 rtl/mem_stage_sram_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: drives a single-port 32-bit SRAM with a fixed
// wait-state count and holds ready low (pipeline freeze) until the access completes.
module mem_stage_sram_ctrl #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_R_EN,
    input  logic              MEM_W_EN,
    input  logic [31:0]       ALU_result,
    input  logic [31:0]       Val_Rm,
    output logic [31:0]       read_data,
    output logic              ready,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic [31:0]       SRAM_DQ_out,
    output logic              SRAM_DQ_oe,
    output logic              SRAM_WE_N,
    input  logic [31:0]       SRAM_DQ_in
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] count;
    logic       op_wr;
    logic       req;

    assign req = MEM_R_EN | MEM_W_EN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes decode from state so reset releases the bus without waiting for a clock.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        SRAM_WE_N  = 1'b1;
        SRAM_DQ_oe = 1'b0;
        unique case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                SRAM_WE_N  = ~op_wr;
                SRAM_DQ_oe = op_wr;
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            op_wr       <= 1'b0;
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            read_data   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        // Write wins when both enables are set.
                        SRAM_ADDR   <= ADDR_W'((ALU_result - 32'(BASE_ADDR)) >> 2);
                        SRAM_DQ_out <= Val_Rm;
                        op_wr       <= MEM_W_EN;
                        count       <= 4'(WAIT_CYCLES - 1);
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        if (!op_wr) begin
                            read_data <= SRAM_DQ_in;
                        end
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
